alu_seq: RTL and testbench

//  Parametrised, handshaked successor of the 8-bit combinational ALU. Accepts one op per

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU with shifts and an iterative shift-add multiplier.
// One op is accepted per valid/ready transfer; results and flags are held until consumed.

module alu_seq #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal,
    output logic             lessThan,
    output logic             carry,
    output logic             illegal
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        HOLD     = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SUB  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTE = 4'd6,
        OP_EQ   = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_MUL  = 4'd10
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             equal_q, equal_d;
    logic             less_q, less_d;
    logic             carry_q, carry_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    logic [WIDTH:0]   sum_ext;
    logic [SHW-1:0]   shamt;
    logic             cmp_eq;
    logic             cmp_lt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_illegal;
    logic [WIDTH-1:0] acc_step;
    logic             accept;

    // Single-cycle datapath: result, carry and illegal flag for every non-multiply opcode.
    always_comb begin
        sum_ext     = {1'b0, op1} + {1'b0, op2};
        shamt       = op2[SHW-1:0];
        cmp_eq      = (op1 == op2);
        if (SIGNED_CMP) begin
            cmp_lt = ($signed(op1) < $signed(op2));
        end else begin
            cmp_lt = (op1 < op2);
        end
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        case (aluop)
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = op1 - op2;
                alu_carry = (op1 < op2);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, cmp_lt};
            OP_SLTE: alu_res = {{(WIDTH-1){1'b0}}, cmp_lt | cmp_eq};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, cmp_eq};
            OP_SHL:  alu_res = op1 << shamt;
            OP_SHR:  alu_res = op1 >> shamt;
            OP_MUL:  alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Next-state logic: handshake, multiplier stepping and output register updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        equal_d   = equal_q;
        less_d    = less_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        accept    = in_valid && in_ready;

        case (state_q)
            MUL_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    result_d = acc_step;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            equal_d = cmp_eq;
            less_d  = cmp_lt;
            if (aluop == OP_MUL) begin
                state_d   = MUL_BUSY;
                count_d   = '0;
                acc_d     = '0;
                mcand_d   = op1;
                mplier_d  = op2;
                carry_d   = 1'b0;
                illegal_d = 1'b0;
            end else begin
                state_d   = HOLD;
                result_d  = alu_res;
                carry_d   = alu_carry;
                illegal_d = alu_illegal;
            end
        end
    end

    // State, output and multiplier registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            equal_q   <= 1'b0;
            less_q    <= 1'b0;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            equal_q   <= equal_d;
            less_q    <= less_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign equal     = equal_q;
    assign lessThan  = less_q;
    assign carry     = carry_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq, WIDTH=8, unsigned and signed compare
// instances driven with identical stimulus.

module tb_alu_seq;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0] res_u;
        logic [7:0] res_s;
        logic       eq;
        logic       lt_u;
        logic       lt_s;
        logic       cy;
        logic       ill;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [3:0] aluop;

    logic       in_ready_u, out_valid_u, equal_u, less_u, carry_u, illegal_u;
    logic [7:0] result_u;
    logic       in_ready_s, out_valid_s, equal_s, less_s, carry_s, illegal_s;
    logic [7:0] result_s;

    int   total = 0;
    int   bad = 0;
    int   n_expected = 0;
    int   n_popped = 0;
    int   edges;
    exp_t exp_q[$];

    alu_seq #(.WIDTH(WIDTH), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .op1(op1), .op2(op2), .aluop(aluop), .out_valid(out_valid_u),
        .out_ready(out_ready), .result(result_u), .equal(equal_u),
        .lessThan(less_u), .carry(carry_u), .illegal(illegal_u)
    );

    alu_seq #(.WIDTH(WIDTH), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .op1(op1), .op2(op2), .aluop(aluop), .out_valid(out_valid_s),
        .out_ready(out_ready), .result(result_s), .equal(equal_s),
        .lessThan(less_s), .carry(carry_s), .illegal(illegal_s)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one op, giving results for both compare modes.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t       e;
        logic [8:0] s;
        int         p;
        e      = '0;
        e.eq   = (a == b);
        e.lt_u = (a < b);
        e.lt_s = ($signed(a) < $signed(b));
        case (op)
            4'd0: begin e.res_u = a & b; e.res_s = a & b; end
            4'd1: begin e.res_u = a | b; e.res_s = a | b; end
            4'd2: begin e.res_u = a ^ b; e.res_s = a ^ b; end
            4'd3: begin
                s = {1'b0, a} + {1'b0, b};
                e.res_u = s[7:0]; e.res_s = s[7:0]; e.cy = s[8];
            end
            4'd4: begin e.res_u = a - b; e.res_s = a - b; e.cy = (a < b); end
            4'd5: begin e.res_u = {7'd0, a < b}; e.res_s = {7'd0, $signed(a) < $signed(b)}; end
            4'd6: begin e.res_u = {7'd0, a <= b}; e.res_s = {7'd0, $signed(a) <= $signed(b)}; end
            4'd7: begin e.res_u = {7'd0, a == b}; e.res_s = {7'd0, a == b}; end
            4'd8: begin e.res_u = a << b[2:0]; e.res_s = a << b[2:0]; end
            4'd9: begin e.res_u = a >> b[2:0]; e.res_s = a >> b[2:0]; end
            4'd10: begin
                p = int'(a) * int'(b);
                e.res_u = p[7:0]; e.res_s = p[7:0];
            end
            default: begin e.res_u = 8'd0; e.res_s = 8'd0; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one op that the bench knows will be accepted at the next edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        in_valid = 1'b1;
        op1      = a;
        op2      = b;
        aluop    = op;
        n_expected++;
        step();
    endtask

    // Scoreboard monitor: sampled mid-cycle, push on input transfer, pop on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid_u && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out", out_valid_u, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    n_popped++;
                    checkOutput("res_u", result_u, e.res_u);
                    checkOutput("res_s", result_s, e.res_s);
                    checkOutput("valid_s", out_valid_s, 1'b1);
                    checkOutput("equal", equal_u, e.eq);
                    checkOutput("lt_u", less_u, e.lt_u);
                    checkOutput("lt_s", less_s, e.lt_s);
                    checkOutput("carry", carry_u, e.cy);
                    checkOutput("illegal", illegal_u, e.ill);
                end
            end
            if (in_valid && in_ready_u) begin
                exp_q.push_back(model(op1, op2, aluop));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op1       = 8'd0;
        op2       = 8'd0;
        aluop     = 4'd0;
        step();
        step();
        checkOutput("rst_out_valid", out_valid_u, 1'b0);
        checkOutput("rst_result", result_u, 8'h00);
        checkOutput("rst_flags", {equal_u, less_u, carry_u, illegal_u}, 4'b0000);
        checkOutput("rst_in_ready", in_ready_u, 1'b1);
        rst_n = 1'b1;
        step();

        // Logic ops back to back, one per cycle.
        out_ready = 1'b1;
        applyStimulus(8'h0F, 8'hF0, 4'd0);
        checkOutput("lat1_valid", out_valid_u, 1'b1);
        checkOutput("and_result", result_u, 8'h00);
        applyStimulus(8'h0F, 8'hF0, 4'd1);
        checkOutput("or_result", result_u, 8'hFF);
        applyStimulus(8'h0F, 8'hF0, 4'd2);
        in_valid = 1'b0;
        step();
        checkOutput("idle_valid", out_valid_u, 1'b0);

        // Add with carry, subtract without borrow.
        applyStimulus(8'hFF, 8'h02, 4'd3);
        checkOutput("add_carry", {carry_u, result_u}, 9'h101);
        applyStimulus(8'h03, 8'h02, 4'd4);
        in_valid = 1'b0;
        step();

        // Compares and shifts; signed/unsigned instances diverge on 0x80.
        applyStimulus(8'h80, 8'h01, 4'd5);
        checkOutput("slt_u", result_u, 8'h00);
        checkOutput("slt_s", result_s, 8'h01);
        applyStimulus(8'h80, 8'h80, 4'd6);
        applyStimulus(8'h01, 8'h80, 4'd6);
        applyStimulus(8'h55, 8'h55, 4'd7);
        applyStimulus(8'h81, 8'h0B, 4'd8);
        applyStimulus(8'h81, 8'hF9, 4'd9);
        in_valid = 1'b0;
        step();

        // Multiply: ignored input while busy, result appears WIDTH edges after accepting edge.
        applyStimulus(8'h0D, 8'h0B, 4'd10);
        op1   = 8'hAA;
        op2   = 8'h55;
        aluop = 4'd0;
        edges = 0;
        while (!out_valid_u && edges < 20) begin
            checkOutput("busy_in_ready", in_ready_u, 1'b0);
            step();
            edges++;
        end
        in_valid = 1'b0;
        checkOutput("mul_latency", edges, WIDTH);
        checkOutput("mul_result", result_u, 8'h8F);
        step();

        // Backpressure: result held, op queued until consumer is ready.
        out_ready = 1'b0;
        applyStimulus(8'h3C, 8'h0F, 4'd0);
        in_valid = 1'b1;
        op1      = 8'h01;
        op2      = 8'h01;
        aluop    = 4'd7;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_result", result_u, 8'h0C);
            checkOutput("bp_in_ready", in_ready_u, 1'b0);
            checkOutput("bp_valid", out_valid_u, 1'b1);
            step();
        end
        out_ready = 1'b1;
        n_expected++;
        step();
        checkOutput("bp_eq_result", result_u, 8'h01);
        checkOutput("bp_eq_flag", equal_u, 1'b1);
        in_valid = 1'b0;
        step();

        // Reset in the middle of a multiply aborts it.
        applyStimulus(8'h0D, 8'h0B, 4'd10);
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", out_valid_u, 1'b0);
        checkOutput("abort_result", result_u, 8'h00);
        checkOutput("abort_flags", {equal_u, less_u, carry_u, illegal_u}, 4'b0000);
        checkOutput("abort_in_ready", in_ready_u, 1'b1);
        exp_q.delete();
        n_expected--;
        step();
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_valid", out_valid_u, 1'b0);

        // Recovery add, then an illegal opcode.
        applyStimulus(8'h05, 8'h07, 4'd3);
        checkOutput("post_rst_add", result_u, 8'h0C);
        applyStimulus(8'h12, 8'h34, 4'd12);
        checkOutput("illegal_flag", {illegal_u, result_u}, 9'h100);
        in_valid = 1'b0;
        step();
        step();

        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("outputs_seen", n_popped, n_expected);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
